// File: rtl/div_iter_unit_pkg.sv
// div_iter_unit_pkg: state codes and bus widths shared by the divider and its EX-stage hookup.
package div_iter_unit_pkg;
    localparam int DIV_DW       = 32;
    localparam int DIV_TO_EX_WD = 2 * DIV_DW + 1;
    localparam int EX_TO_DIV_WD = 2 * DIV_DW + 3;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;
endpackage

// File: rtl/div_iter_unit.sv
// div_iter_unit: multi-cycle restoring radix-2 DIV/DIVU, one quotient bit per clock.
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int DW = DIV_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic [DW-1:0]   opdata1_i,
    input  logic [DW-1:0]   opdata2_i,
    input  logic            annul_i,
    output logic [2*DW-1:0] result_o,
    output logic            ready_o,
    output logic            stallreq_o
);
    localparam int CW = $clog2(DW);
    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*DW:0]   w_q, w_d, w_shift, w_step;
    logic [DW-1:0]   op2_q, op2_d, abs1, abs2;
    logic            qneg_q, qneg_d, rneg_q, rneg_d;
    logic [2*DW-1:0] result_q, result_d;
    logic [DW:0]     diff;
    assign abs1    = (signed_i && opdata1_i[DW-1]) ? -opdata1_i : opdata1_i;
    assign abs2    = (signed_i && opdata2_i[DW-1]) ? -opdata2_i : opdata2_i;
    assign w_shift = {w_q[2*DW-1:0], 1'b0};
    assign diff    = w_shift[2*DW:DW] - {1'b0, op2_q};
    // A clear borrow bit means the trial subtraction fits: keep it and set the quotient bit.
    assign w_step  = diff[DW] ? w_shift : {diff, w_shift[DW-1:1], 1'b1};
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_d      = w_q;
        op2_d    = op2_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        case (state_q)
            DIV_FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d = DIV_ON;
                        cnt_d   = '0;
                        w_d     = {{(DW+1){1'b0}}, abs1};
                        op2_d   = abs2;
                        qneg_d  = signed_i && (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
                        rneg_d  = signed_i && opdata1_i[DW-1];
                    end
                end
            end
            DIV_BY_ZERO: begin
                state_d  = DIV_END;
                result_d = '0;
            end
            DIV_ON: begin
                w_d   = w_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d  = DIV_END;
                    result_d = {rneg_q ? -w_step[2*DW-1:DW] : w_step[2*DW-1:DW],
                                qneg_q ? -w_step[DW-1:0]    : w_step[DW-1:0]};
                end
            end
            default: begin
                if (!start_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                end
            end
        endcase
        if (annul_i && state_q != DIV_FREE) begin
            state_d  = DIV_FREE;
            result_d = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            w_q      <= '0;
            op2_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            op2_q    <= op2_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end
    assign result_o   = result_q;
    assign ready_o    = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    assign stallreq_o = start_i & ~ready_o;
endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: directed DIV/DIVU vectors checked against literals and an arithmetic reference model.
module tb_div_iter_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;
    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    div_iter_unit dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
    );
    always #5 clk = ~clk;
    function automatic logic [63:0] golden(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return 64'd0;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Reference model: latency counted in edges from acceptance, result from plain arithmetic.
    bit          m_busy = 0, m_done = 0;
    int          m_edges = 0, m_lat = 0;
    logic [63:0] m_res = '0, m_pend = '0;
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_res <= '0;
        end else if (m_done) begin
            if (annul_i || !start_i) begin m_done <= 0; m_res <= '0; end
        end else if (m_busy) begin
            if (annul_i) m_busy <= 0;
            else begin
                m_edges <= m_edges + 1;
                if (m_edges + 1 == m_lat) begin m_busy <= 0; m_done <= 1; m_res <= m_pend; end
            end
        end else if (start_i && !annul_i) begin
            m_busy  <= 1;
            m_edges <= 1;
            m_lat   <= (opdata2_i == 0) ? 2 : 33;
            m_pend  <= golden(signed_i, opdata1_i, opdata2_i);
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ready", 64'(ready_o), 64'(m_done));
            check("model_stall", 64'(stallreq_o), 64'(start_i & ~m_done));
            check("model_result", result_o, m_res);
        end
    end
    task automatic run_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int exp_lat, input int hold);
        int edges;
        @(negedge clk);
        signed_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!ready_o && edges < 100);
        check({name, "_latency"}, 64'(edges), 64'(exp_lat));
        check({name, "_result"}, result_o, exp);
        opdata1_i = $urandom; opdata2_i = $urandom; signed_i = ~s;
        repeat (hold) begin
            @(posedge clk); #1;
            check({name, "_hold_ready"}, 64'(ready_o), 64'd1);
            check({name, "_hold_result"}, result_o, exp);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({name, "_drop_ready"}, 64'(ready_o), 64'd0);
        check({name, "_drop_result"}, result_o, 64'd0);
        @(negedge clk);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("divu_7_2",      1'b0, 32'd7,          32'd2,          64'h00000001_00000003, 33, 0);
        run_div("div_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, 0);
        run_div("div_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 0);
        run_div("divu_5_0",      1'b0, 32'd5,          32'd0,          64'h0,                 2,  0);
        run_div("div_min_m1",    1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, 0);
        run_div("divu_max_1",    1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33, 0);
        run_div("divu_100_7",    1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, 3);
        run_div("div_m100_m7",   1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33, 0);
        // Flush after 10 working cycles, then a fresh division must still take the full latency.
        @(negedge clk);
        signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_result", result_o, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("annul_idle_ready", 64'(ready_o), 64'd0);
        end
        run_div("after_annul",   1'b0, 32'd1000,       32'd3,          64'h00000001_0000014D, 33, 0);
        // Reset in the middle of a division discards it.
        @(negedge clk);
        signed_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ready", 64'(ready_o), 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        check("rst_mid_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("after_rst",     1'b1, 32'd50,         32'd5,          64'h00000000_0000000A, 33, 0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
